// File: rtl/cacheline_adaptor.sv
// Cache line <-> memory burst adaptor.
// Turns one 256-bit line read/write from the cache side into a 4-beat,
// 64-bit burst on the memory side. Beats may have gaps (resp_i low).
// A one-cycle resp_o pulse reports completion back to the cache.
module cacheline_adaptor (
  input  logic         clk,
  input  logic         rst,
  // cache side
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  input  logic [31:0]  address_i,
  input  logic         read_i,
  input  logic         write_i,
  output logic         resp_o,
  // memory side
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]   state_reg;
  logic [1:0]   count_reg;
  logic [31:0]  address_reg;
  logic [255:0] rline_reg;   // line assembled from memory reads
  logic [255:0] wline_reg;   // line latched for a memory write

  // The low five address bits select a byte within the line; the memory
  // side always sees a line-aligned address, so they are never used.
  logic unused_addr_bits;
  assign unused_addr_bits = ^address_i[4:0];

  // Split the latched write line into its four beats for the output mux.
  logic [63:0] wbeat [4];
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wbeat
      assign wbeat[gi] = wline_reg[64*gi +: 64];
    end
  endgenerate

  // Control state, beat counter, address and data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= 2'd0;
      address_reg <= 32'd0;
      rline_reg   <= 256'd0;
      wline_reg   <= 256'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          // Read has priority; a simultaneous write is dropped, not queued.
          if (read_i) begin
            address_reg <= {address_i[31:5], 5'b0};
            count_reg   <= 2'd0;
            state_reg   <= READ;
          end else if (write_i) begin
            address_reg <= {address_i[31:5], 5'b0};
            wline_reg   <= line_i;
            count_reg   <= 2'd0;
            state_reg   <= WRITE;
          end
        end
        READ: begin
          if (resp_i) begin
            rline_reg[{count_reg, 6'd0} +: 64] <= burst_i;
            count_reg <= count_reg + 2'd1;   // wraps to 0 after beat 3
            if (count_reg == 2'd3) begin
              state_reg <= DONE;
            end
          end
        end
        WRITE: begin
          if (resp_i) begin
            count_reg <= count_reg + 2'd1;
            if (count_reg == 2'd3) begin
              state_reg <= DONE;
            end
          end
        end
        default: begin
          // DONE: single completion cycle, requests here are ignored.
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign read_o    = (state_reg == READ);
  assign write_o   = (state_reg == WRITE);
  assign resp_o    = (state_reg == DONE);
  assign address_o = address_reg;
  assign line_o    = rline_reg;
  assign burst_o   = wbeat[count_reg];

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Self-checking bench for cacheline_adaptor: directed scenarios plus
// randomized reads/writes with random beat gaps, checked cycle by cycle
// against a transaction-level expectation (beats accepted so far).
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic [31:0]  address_i;
  logic         read_i;
  logic         write_i;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int total = 0;
  int bad   = 0;
  logic [255:0] last_line;   // line_o content expected to persist

  cacheline_adaptor dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // One cache read. Outputs are checked on the negedge, inputs for the next
  // posedge are driven right after. hold keeps read_i high throughout;
  // pre means the request was already presented by the previous call.
  task automatic run_read(input logic [31:0] addr, input logic [255:0] line,
                          input bit use_pat, input logic [5:0] pat,
                          input bit also_write, input bit hold, input bit pre);
    int acc;
    int cyc;
    bit r;
    logic [31:0] al;
    al = {addr[31:5], 5'b0};
    if (!pre) begin
      @(negedge clk);
      total++;
      if ({read_o, write_o, resp_o} !== 3'b000) begin
        bad++; $display("FAIL rd_idle got=%b exp=000", {read_o, write_o, resp_o});
      end
      read_i = 1'b1; write_i = also_write; address_i = addr; line_i = rnd256();
      resp_i = 1'($urandom_range(0, 1)); burst_i = {$urandom, $urandom};
    end
    @(negedge clk);
    if (!hold) begin
      read_i = 1'b0; address_i = $urandom;
    end
    write_i = 1'b0; line_i = rnd256();
    acc = 0; cyc = 0;
    while (acc < 4 && cyc < 100) begin
      total++;
      if ({read_o, write_o, resp_o} !== 3'b100) begin
        bad++; $display("FAIL rd_ctl beat=%0d got=%b exp=100", acc, {read_o, write_o, resp_o});
      end
      total++;
      if (address_o !== al) begin
        bad++; $display("FAIL rd_addr got=%h exp=%h", address_o, al);
      end
      if (acc == 0) begin
        total++;
        if (line_o !== last_line) begin
          bad++; $display("FAIL rd_line_hold got=%h exp=%h", line_o, last_line);
        end
      end
      r = use_pat ? ((cyc < 6) ? pat[cyc] : 1'b1) : ($urandom_range(0, 2) != 0);
      if (r) begin
        resp_i = 1'b1; burst_i = line[64*acc +: 64]; acc++;
      end else begin
        resp_i = 1'b0; burst_i = {$urandom, $urandom};
      end
      cyc++;
      @(negedge clk);
    end
    if (acc < 4) begin
      total++; bad++;
      $display("FAIL rd_timeout beats=%0d exp=4", acc);
    end
    resp_i = 1'b0; burst_i = {$urandom, $urandom};
    total++;
    if ({read_o, write_o, resp_o} !== 3'b001) begin
      bad++; $display("FAIL rd_done got=%b exp=001", {read_o, write_o, resp_o});
    end
    total++;
    if (line_o !== line) begin
      bad++; $display("FAIL rd_line got=%h exp=%h", line_o, line);
    end
    total++;
    if (address_o !== al) begin
      bad++; $display("FAIL rd_addr_done got=%h exp=%h", address_o, al);
    end
    last_line = line;
    @(negedge clk);
    total++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      bad++; $display("FAIL rd_after got=%b exp=000", {read_o, write_o, resp_o});
    end
    if (hold) resp_i = 1'b1;   // stray beat while idle
    $display("read  addr=%h line=%h", al, line);
  endtask

  // One cache write with beats accepted per pattern or at random.
  task automatic run_write(input logic [31:0] addr, input logic [255:0] line,
                           input bit use_pat, input logic [5:0] pat);
    int acc;
    int cyc;
    bit r;
    logic [31:0] al;
    al = {addr[31:5], 5'b0};
    @(negedge clk);
    total++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      bad++; $display("FAIL wr_idle got=%b exp=000", {read_o, write_o, resp_o});
    end
    read_i = 1'b0; write_i = 1'b1; address_i = addr; line_i = line; resp_i = 1'b0;
    @(negedge clk);
    write_i = 1'b0; address_i = $urandom; line_i = rnd256();
    acc = 0; cyc = 0;
    while (acc < 4 && cyc < 100) begin
      total++;
      if ({read_o, write_o, resp_o} !== 3'b010) begin
        bad++; $display("FAIL wr_ctl beat=%0d got=%b exp=010", acc, {read_o, write_o, resp_o});
      end
      total++;
      if (burst_o !== line[64*acc +: 64]) begin
        bad++; $display("FAIL wr_burst beat=%0d got=%h exp=%h", acc, burst_o, line[64*acc +: 64]);
      end
      total++;
      if (address_o !== al || line_o !== last_line) begin
        bad++; $display("FAIL wr_addr_line addr=%h exp=%h", address_o, al);
      end
      r = use_pat ? ((cyc < 6) ? pat[cyc] : 1'b1) : ($urandom_range(0, 2) != 0);
      resp_i = r;
      burst_i = {$urandom, $urandom};
      if (r) acc++;
      cyc++;
      @(negedge clk);
    end
    if (acc < 4) begin
      total++; bad++;
      $display("FAIL wr_timeout beats=%0d exp=4", acc);
    end
    resp_i = 1'b0;
    total++;
    if ({read_o, write_o, resp_o} !== 3'b001) begin
      bad++; $display("FAIL wr_done got=%b exp=001", {read_o, write_o, resp_o});
    end
    @(negedge clk);
    total++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      bad++; $display("FAIL wr_after got=%b exp=000", {read_o, write_o, resp_o});
    end
    $display("write addr=%h line=%h", al, line);
  endtask

  task automatic test_reset();
    rst = 1'b1; read_i = 1'b1; write_i = 1'b1; resp_i = 1'b1;
    address_i = 32'hFFFF_FFFF; line_i = rnd256(); burst_i = {$urandom, $urandom};
    @(negedge clk);
    @(negedge clk);
    total++;
    if ({read_o, write_o, resp_o} !== 3'b000 || address_o !== 32'd0 ||
        line_o !== 256'd0 || burst_o !== 64'd0) begin
      bad++; $display("FAIL reset ctl=%b addr=%h burst=%h exp all zero",
                      {read_o, write_o, resp_o}, address_o, burst_o);
    end
    rst = 1'b0; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    last_line = '0;
    $display("reset checked");
  endtask

  task automatic test_read_b2b();
    logic [255:0] l;
    l = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    run_read(32'h0000_1234, l, 1'b1, 6'b111111, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_write_gaps();
    run_write(32'hABCD_0057, rnd256(), 1'b1, 6'b111001);
  endtask

  task automatic test_simultaneous();
    run_read(32'h8000_00FF, rnd256(), 1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid_read();
    @(negedge clk);
    read_i = 1'b1; address_i = 32'h1234_5678;
    @(negedge clk);
    read_i = 1'b0; resp_i = 1'b1; burst_i = {$urandom, $urandom};
    @(negedge clk);
    burst_i = {$urandom, $urandom};
    @(negedge clk);
    rst = 1'b1; burst_i = {$urandom, $urandom};
    @(negedge clk);
    total++;
    if ({read_o, write_o, resp_o} !== 3'b000 || address_o !== 32'd0 ||
        line_o !== 256'd0 || burst_o !== 64'd0) begin
      bad++; $display("FAIL mid_reset ctl=%b addr=%h exp all zero",
                      {read_o, write_o, resp_o}, address_o);
    end
    rst = 1'b0; resp_i = 1'b0; last_line = '0;
    @(negedge clk);
    total++;
    if ({read_o, write_o, resp_o} !== 3'b000) begin
      bad++; $display("FAIL mid_reset_resp got=%b exp=000", {read_o, write_o, resp_o});
    end
    $display("reset during read checked");
    run_read($urandom, rnd256(), 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_read_held();
    logic [31:0] a;
    a = $urandom;
    run_read(a, rnd256(), 1'b1, 6'b111111, 1'b0, 1'b1, 1'b0);
    run_read(a, rnd256(), 1'b0, 6'd0, 1'b0, 1'b1, 1'b1);
    read_i = 1'b0; resp_i = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 1) == 0)
        run_read($urandom, rnd256(), 1'b0, 6'd0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      else
        run_write($urandom, rnd256(), 1'b0, 6'd0);
    end
  endtask

  initial begin
    rst = 1'b1; read_i = 1'b0; write_i = 1'b0; resp_i = 1'b0;
    address_i = '0; line_i = '0; burst_i = '0; last_line = '0;
    test_reset();
    test_read_b2b();
    test_write_gaps();
    test_simultaneous();
    test_reset_mid_read();
    test_read_held();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cacheline_adaptor.md
CACHELINE_ADAPTOR -- requirements
Module: cacheline_adaptor

Interface
REQ-001 Parameters: none; line width is fixed at 256 bits, burst width at 64 bits and burst length at 4 beats.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 line_i  input  256  cache line to be written to memory.
REQ-005 line_o  output  256  cache line assembled from a memory read.
REQ-006 address_i  input  32  cache-side request address.
REQ-007 read_i  input  1  cache-side line read request, level.
REQ-008 write_i  input  1  cache-side line write request, level.
REQ-009 resp_o  output  1  cache-side completion, one-cycle pulse.
REQ-010 burst_i  input  64  memory read data beat.
REQ-011 burst_o  output  64  memory write data beat.
REQ-012 address_o  output  32  memory-side address, line aligned.
REQ-013 read_o  output  1  memory-side read request.
REQ-014 write_o  output  1  memory-side write request.
REQ-015 resp_i  input  1  memory-side beat valid/accept, one beat per cycle high.

Function
REQ-016 The FSM SHALL have the states IDLE, READ, WRITE and DONE, with a 2-bit beat counter.
REQ-017 In IDLE with read_i=1: latch {address_i[31:5],5'b0} into address_o, clear the counter, and go to READ.
REQ-018 In IDLE with write_i=1 and read_i=0: latch the aligned address and line_i, clear the counter, and go to WRITE.
REQ-019 If read_i and write_i are both 1 in IDLE, read SHALL win; the write is not queued.
REQ-020 read_o SHALL be 1 exactly while in READ; write_o SHALL be 1 exactly while in WRITE; the two SHALL never be 1 together.
REQ-021 In READ, each cycle with resp_i=1 SHALL capture burst_i into line_o[64k+63:64k] (k = counter) and increment k.
REQ-022 Cycles with resp_i=0 in READ or WRITE SHALL hold the counter and data; gaps between beats are legal.
REQ-023 In WRITE, burst_o SHALL equal latched_line[64k+63:64k] combinationally from k; on each resp_i=1, k increments.
REQ-024 Accepting beat k=3 (resp_i=1) in READ or WRITE SHALL transition to DONE on the next edge, with the counter wrapping to 0.
REQ-025 In DONE, resp_o SHALL be 1 for exactly one cycle, then the FSM returns to IDLE.
REQ-026 The minimum request-to-resp_o latency is 6 cycles: request sampled at edge 0, beats at cycles 1-4, resp_o at cycle 5.
REQ-027 line_o SHALL hold the assembled line from DONE until the next read's first beat is captured.
REQ-028 read_i/write_i seen outside IDLE (including during DONE) SHALL be ignored; a request still held in the cycle after DONE is treated as a new request.
REQ-029 address_o SHALL stay stable from request acceptance through DONE.
REQ-030 resp_i while in IDLE or DONE SHALL be ignored.
REQ-031 address_i and line_i SHALL not be sampled except at acceptance in IDLE.

Reset
REQ-032 With rst=1 at a posedge: state -> IDLE, counter -> 0, resp_o/read_o/write_o -> 0, address_o -> 0, line_o -> 0, latched write line -> 0 (so burst_o -> 0).
REQ-033 Reset SHALL win over all other inputs in the same cycle, and reset mid-READ or mid-WRITE SHALL abort without producing resp_o.

Verification
REQ-034 Read, back-to-back beats: read_i=1, address_i=0x0000_1234, beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 on consecutive resp_i -> address_o=0x0000_1220, read_o high 4 cycles, resp_o pulses once at cycle 5, line_o={0x44..,0x33..,0x22..,0x11..}.
REQ-035 Write with gaps: line_i = beats A,B,C,D (low to high); resp_i high, low, low, high, high, high -> burst_o shows A,B,B,B,C,D at those cycles, write_o drops after the 4th accept, resp_o pulses once.
REQ-036 Simultaneous read_i=1 and write_i=1 in IDLE -> only read_o asserts, and the write_i path produces no burst.
REQ-037 Reset after 2 read beats -> next cycle all outputs 0, no resp_o; a new read then completes normally with a fresh line.
REQ-038 read_i held high continuously -> two complete reads separated by exactly one IDLE cycle after resp_o; stray resp_i in IDLE causes no state change.
